// File: rtl/tcs3472_pkg.sv
// tcs3472_pkg: shared constants and types for the TCS3472 measurement sequencer.
//   - command-byte prefix and register addresses of the sensor
//   - values written to the ENABLE register
//   - FSM state / bus-handshake phase encodings
//   - bus request record driven onto the I2C master command interface
package tcs3472_pkg;

    localparam int TMR_W = 21;  // shared wait/timeout down-counter width

    localparam logic [7:0] CMD_BIT    = 8'h80;
    localparam logic [7:0] REG_ENABLE = 8'h00;
    localparam logic [7:0] REG_ATIME  = 8'h01;
    localparam logic [7:0] REG_CDATAL = 8'h14;

    localparam logic [7:0] EN_OFF     = 8'h00;
    localparam logic [7:0] EN_PON     = 8'h01;
    localparam logic [7:0] EN_PON_AEN = 8'h03;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_PON   = 4'd1,
        ST_WAIT_PON = 4'd2,
        ST_WR_ATIME = 4'd3,
        ST_WR_AEN   = 4'd4,
        ST_WAIT_INT = 4'd5,
        ST_RD_BURST = 4'd6,
        ST_PUBLISH  = 4'd7,
        ST_WR_OFF   = 4'd8,
        ST_ERROR    = 4'd9
    } state_t;

    // Handshake phase inside any bus-transaction state.
    typedef enum logic [1:0] {
        PH_ISSUE = 2'd0,  // command fields driven, timeout armed
        PH_WAIT  = 2'd1,  // start held until first done
        PH_REL   = 2'd2   // start dropped, wait for done to fall
    } phase_t;

    typedef struct packed {
        logic       rw;
        logic [7:0] reg_addr;
        logic [7:0] data;
    } txn_req_t;

    function automatic logic [7:0] cmd_byte(input logic [7:0] reg_addr);
        return CMD_BIT | reg_addr;
    endfunction

endpackage

// File: rtl/tcs3472_ctrl_timer.sv
// tcs_wait_timer: single shared down-counter for power-up, integration and
// bus-timeout waits (they never overlap).
//   clk, rst  : clock, async active-high reset (count cleared)
//   load      : load load_val this cycle (priority over decrement)
//   load_val  : value to load
//   zero      : count has reached zero; counter holds at zero
module tcs_wait_timer
    import tcs3472_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tcs3472_ctrl.sv
// tcs3472_ctrl: TCS3472 measurement sequencer.
// Powers the sensor up, programs ATIME, enables the ADC, then repeatedly waits
// one integration period and reads CDATAL..BDATAH, publishing all four
// channels together with a one-cycle sample_valid strobe.
//   clk, rst            : clock, async active-high reset
//   enable              : 1 = measure continuously, 0 = power down and idle
//   i2c_start/rw/addr/reg_addr/data_wr : command to the single-byte I2C master
//   i2c_data_rd, i2c_done               : result / completion from the master
//   clear_o..blue_o     : last published channel values
//   sample_valid        : one-cycle pulse when channel outputs update
//   busy                : high in every state except IDLE and ERROR
//   error               : bus timeout; held until enable drops
module tcs3472_ctrl
    import tcs3472_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h29,
    parameter logic [7:0] ATIME_VAL  = 8'hF6,
    parameter int         PON_WAIT   = 125000,
    parameter int         INTEG_WAIT = 1500000,
    parameter int         TIMEOUT    = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        i2c_start,
    output logic        i2c_rw,
    output logic [6:0]  i2c_addr,
    output logic [7:0]  i2c_reg_addr,
    output logic [7:0]  i2c_data_wr,
    input  logic [7:0]  i2c_data_rd,
    input  logic        i2c_done,
    output logic [15:0] clear_o,
    output logic [15:0] red_o,
    output logic [15:0] green_o,
    output logic [15:0] blue_o,
    output logic        sample_valid,
    output logic        busy,
    output logic        error
);

    state_t           state, state_n;
    phase_t           phase, phase_n;
    logic [2:0]       idx, idx_n;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             is_txn;
    logic             txn_done;
    txn_req_t         req;
    logic [7:0]       low_sh;
    logic [3:0][15:0] ch_sh;  // C, R, G, B

    tcs_wait_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign is_txn = (state == ST_WR_PON)   || (state == ST_WR_ATIME) ||
                    (state == ST_WR_AEN)   || (state == ST_RD_BURST) ||
                    (state == ST_WR_OFF);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            phase <= PH_ISSUE;
            idx   <= '0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            idx   <= idx_n;
        end
    end

    // Next state. enable is only sampled once a transfer has fully released,
    // so a bus transfer is never cut short.
    always_comb begin
        state_n  = state;
        phase_n  = phase;
        idx_n    = idx;
        tmr_load = 1'b0;
        tmr_val  = '0;
        txn_done = 1'b0;

        if (is_txn) begin
            case (phase)
                PH_ISSUE: begin
                    phase_n  = PH_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT);
                end
                PH_WAIT: begin
                    if (i2c_done)
                        phase_n = PH_REL;
                    else if (tmr_zero) begin
                        state_n = ST_ERROR;
                        phase_n = PH_ISSUE;
                    end
                end
                PH_REL: begin
                    if (!i2c_done) begin
                        txn_done = 1'b1;
                        phase_n  = PH_ISSUE;
                    end
                end
                default: phase_n = PH_ISSUE;
            endcase
        end

        case (state)
            ST_IDLE:     if (enable) state_n = ST_WR_PON;
            ST_WR_PON: begin
                if (txn_done) begin
                    if (enable) begin
                        state_n  = ST_WAIT_PON;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(PON_WAIT);
                    end else
                        state_n = ST_WR_OFF;
                end
            end
            ST_WAIT_PON: begin
                if (!enable)       state_n = ST_WR_OFF;
                else if (tmr_zero) state_n = ST_WR_ATIME;
            end
            ST_WR_ATIME: if (txn_done) state_n = enable ? ST_WR_AEN : ST_WR_OFF;
            ST_WR_AEN: begin
                if (txn_done) begin
                    if (enable) begin
                        state_n  = ST_WAIT_INT;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(INTEG_WAIT);
                    end else
                        state_n = ST_WR_OFF;
                end
            end
            ST_WAIT_INT: begin
                if (!enable)
                    state_n = ST_WR_OFF;
                else if (tmr_zero) begin
                    state_n = ST_RD_BURST;
                    idx_n   = '0;
                end
            end
            ST_RD_BURST: begin
                if (txn_done) begin
                    if (!enable)           state_n = ST_WR_OFF;  // drop partial burst
                    else if (idx == 3'd7)  state_n = ST_PUBLISH;
                    else                   idx_n   = idx + 3'd1;
                end
            end
            ST_PUBLISH: begin
                if (enable) begin
                    state_n  = ST_WAIT_INT;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(INTEG_WAIT);
                end else
                    state_n = ST_WR_OFF;
            end
            ST_WR_OFF:   if (txn_done) state_n = ST_IDLE;
            ST_ERROR:    if (!enable)  state_n = ST_IDLE;
            default:     state_n = ST_IDLE;
        endcase
    end

    // Outputs. Command fields stay constant for the whole transaction.
    always_comb begin
        req = '0;
        case (state)
            ST_WR_PON:   req = '{1'b0, cmd_byte(REG_ENABLE), EN_PON};
            ST_WR_ATIME: req = '{1'b0, cmd_byte(REG_ATIME), ATIME_VAL};
            ST_WR_AEN:   req = '{1'b0, cmd_byte(REG_ENABLE), EN_PON_AEN};
            ST_RD_BURST: req = '{1'b1, cmd_byte(REG_CDATAL + {5'd0, idx}), 8'h00};
            ST_WR_OFF:   req = '{1'b0, cmd_byte(REG_ENABLE), EN_OFF};
            default:     req = '0;
        endcase
        i2c_rw       = req.rw;
        i2c_reg_addr = req.reg_addr;
        i2c_data_wr  = req.data;
        i2c_start    = is_txn && (phase == PH_WAIT);
        busy         = (state != ST_IDLE) && (state != ST_ERROR);
        error        = (state == ST_ERROR);
    end

    assign i2c_addr = SLAVE_ADDR;

    // Read capture into shadows; outputs only change on a complete burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_sh       <= '0;
            ch_sh        <= '0;
            clear_o      <= '0;
            red_o        <= '0;
            green_o      <= '0;
            blue_o       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (state == ST_RD_BURST && phase == PH_WAIT && i2c_done) begin
                if (!idx[0])
                    low_sh <= i2c_data_rd;
                else
                    ch_sh[idx[2:1]] <= {i2c_data_rd, low_sh};
            end
            if (state == ST_PUBLISH) begin
                clear_o      <= ch_sh[0];
                red_o        <= ch_sh[1];
                green_o      <= ch_sh[2];
                blue_o       <= ch_sh[3];
                sample_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tcs3472_ctrl.sv
// tb_tcs3472_ctrl: directed self-checking bench for tcs3472_ctrl with a
// behavioural I2C master (done 20 clk after start, held 5 clk).
module tb_tcs3472_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        i2c_start, i2c_rw;
    logic [6:0]  i2c_addr;
    logic [7:0]  i2c_reg_addr, i2c_data_wr, i2c_data_rd;
    logic        i2c_done;
    logic [15:0] clear_o, red_o, green_o, blue_o;
    logic        sample_valid, busy, error;

    int n_chk  = 0;
    int n_fail = 0;

    // mock control and transaction log
    logic       hang_atime = 1'b0;
    logic [7:0] data_ofs   = 8'h00;
    bit         log_rw[$];
    logic [7:0] log_reg[$];
    logic [7:0] log_dat[$];
    time        log_t[$];

    // monitors
    int          start_viol = 0;
    int          glitch     = 0;
    int          addr_bad   = 0;
    int          sv_cnt     = 0;
    logic        start_q    = 1'b0;
    logic [63:0] outs_q     = '0;

    tcs3472_ctrl #(
        .SLAVE_ADDR (7'h29),
        .ATIME_VAL  (8'hF6),
        .PON_WAIT   (10),
        .INTEG_WAIT (50),
        .TIMEOUT    (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .i2c_start    (i2c_start),
        .i2c_rw       (i2c_rw),
        .i2c_addr     (i2c_addr),
        .i2c_reg_addr (i2c_reg_addr),
        .i2c_data_wr  (i2c_data_wr),
        .i2c_data_rd  (i2c_data_rd),
        .i2c_done     (i2c_done),
        .clear_o      (clear_o),
        .red_o        (red_o),
        .green_o      (green_o),
        .blue_o       (blue_o),
        .sample_valid (sample_valid),
        .busy         (busy),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Behavioural I2C master; abandons its transfer if rst is seen.
    always begin : mock
        logic [7:0] r;
        bit         abort;
        @(negedge clk);
        if (!rst && i2c_start) begin
            r = i2c_reg_addr;
            log_rw.push_back(i2c_rw);
            log_reg.push_back(r);
            log_dat.push_back(i2c_data_wr);
            log_t.push_back($time);
            abort = 1'b0;
            if (hang_atime && !i2c_rw && r == 8'h81) begin
                while (i2c_start && !rst) @(negedge clk);
            end else begin
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (rst) begin abort = 1'b1; break; end
                end
                if (!abort) begin
                    i2c_data_rd = (r >= 8'h94 && r <= 8'h9B) ? (r - 8'h83 + data_ofs) : 8'h00;
                    i2c_done    = 1'b1;
                    for (int k = 0; k < 5; k++) @(negedge clk);
                    i2c_done    = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        start_q <= i2c_start;
        outs_q  <= {clear_o, red_o, green_o, blue_o};
        if (i2c_start && !start_q && i2c_done) start_viol <= start_viol + 1;
        if (!rst && !sample_valid && {clear_o, red_o, green_o, blue_o} !== outs_q)
            glitch <= glitch + 1;
        if (i2c_addr !== 7'h29) addr_bad <= addr_bad + 1;
        if (sample_valid) sv_cnt <= sv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int i, input logic [7:0] rg, input logic [7:0] dat);
        check({tag, "_present"}, 32'(log_reg.size() > i), 1);
        if (log_reg.size() > i) begin
            check({tag, "_rw"},  32'(log_rw[i]), 0);
            check({tag, "_reg"}, log_reg[i], rg);
            check({tag, "_dat"}, log_dat[i], dat);
        end
    endtask

    task automatic check_rd(input string tag, input int i, input logic [7:0] rg);
        check({tag, "_present"}, 32'(log_reg.size() > i), 1);
        if (log_reg.size() > i) begin
            check({tag, "_rw"},  32'(log_rw[i]), 1);
            check({tag, "_reg"}, log_reg[i], rg);
        end
    endtask

    task automatic wait_log(input string tag, input int n, input int bound);
        bit got = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (log_reg.size() >= n) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check(tag, 32'(got), 1);
    endtask

    // sel: 0 = sample_valid high, 1 = error high, 2 = busy low
    task automatic wait_sig(input string tag, input int sel, input int bound);
        bit got = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if ((sel == 0 && sample_valid) || (sel == 1 && error) || (sel == 2 && !busy)) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, 32'(got), 1);
    endtask

    task automatic check_outs(input string tag, input logic [15:0] c, input logic [15:0] r,
                              input logic [15:0] g, input logic [15:0] b);
        check({tag, "_clear"}, clear_o, c);
        check({tag, "_red"},   red_o,   r);
        check({tag, "_green"}, green_o, g);
        check({tag, "_blue"},  blue_o,  b);
    endtask

    initial begin
        int  base, base2, base3, gap;
        time t_sv, t_s;

        rst = 1'b1; enable = 1'b0; i2c_done = 1'b0; i2c_data_rd = 8'h00;
        repeat (3) @(negedge clk);

        // reset state
        check_outs("rst", 16'h0, 16'h0, 16'h0, 16'h0);
        check("rst_addr",  i2c_addr, 7'h29);
        check("rst_start", i2c_start, 0);
        check("rst_busy",  busy, 0);
        check("rst_error", error, 0);
        check("rst_sv",    sample_valid, 0);
        check("rst_rw",    i2c_rw, 0);
        check("rst_reg",   i2c_reg_addr, 0);

        // bring-up and first burst
        rst = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        wait_sig("sv1_seen", 0, 2000);
        t_sv = $time;
        check_outs("burst1", 16'h1211, 16'h1413, 16'h1615, 16'h1817);
        check_wr("tx0", 0, 8'h80, 8'h01);
        check_wr("tx1", 1, 8'h81, 8'hF6);
        check_wr("tx2", 2, 8'h80, 8'h03);
        for (int i = 0; i < 8; i++) check_rd($sformatf("rd%0d", i), 3 + i, 8'h94 + 8'(i));
        check("log_after_b1", log_reg.size(), 11);
        data_ofs = 8'h10;
        @(negedge clk);
        check("sv1_width", sample_valid, 0);
        check("sv1_cnt", sv_cnt, 1);

        // enable held: second burst after the integration wait
        wait_log("b2_start", 12, 200);
        if (log_t.size() > 11) begin
            gap = int'((log_t[11] - t_sv) / 10);
            check("b2_gap_range", 32'(gap >= 50 && gap <= 54), 1);
        end
        check_rd("b2_rd0", 11, 8'h94);
        wait_sig("sv2_seen", 0, 1000);
        check_outs("burst2", 16'h2221, 16'h2423, 16'h2625, 16'h2827);
        data_ofs = 8'h30;
        @(negedge clk);
        check("sv2_cnt", sv_cnt, 2);

        // enable dropped during the 4th read of the third burst
        base = log_reg.size();
        check("b3_base", base, 19);
        wait_log("b3_rd3", base + 4, 1000);
        enable = 1'b0;
        wait_sig("off_idle", 2, 500);
        repeat (3) @(negedge clk);
        check_rd("b3_rd3_chk", base + 3, 8'h97);
        check_wr("off_wr", base + 4, 8'h80, 8'h00);
        check("off_log_len", log_reg.size(), base + 5);
        check_outs("off_hold", 16'h2221, 16'h2423, 16'h2625, 16'h2827);
        check("off_sv_cnt", sv_cnt, 2);
        check("off_busy", busy, 0);

        // ATIME write never completes -> timeout
        hang_atime = 1'b1;
        base2 = log_reg.size();
        enable = 1'b1;
        wait_log("to_atime", base2 + 2, 500);
        check_wr("to_pon", base2, 8'h80, 8'h01);
        check_wr("to_atime_w", base2 + 1, 8'h81, 8'hF6);
        t_s = (log_t.size() > base2 + 1) ? log_t[base2 + 1] : $time;
        wait_sig("to_err", 1, 400);
        gap = int'(($time - t_s) / 10);
        check("to_time_range", 32'(gap >= 99 && gap <= 102), 1);
        check("to_busy",  busy, 0);
        check("to_start", i2c_start, 0);
        check_outs("to_hold", 16'h2221, 16'h2423, 16'h2625, 16'h2827);
        repeat (5) @(negedge clk);
        check("to_sticky", error, 1);
        enable = 1'b0;
        hang_atime = 1'b0;
        repeat (3) @(negedge clk);
        check("to_clear", error, 0);
        check("to_idle_busy", busy, 0);
        check("to_no_write", log_reg.size(), base2 + 2);
        enable = 1'b1;
        wait_log("re_pon", base2 + 3, 200);
        check_wr("re_pon_w", base2 + 2, 8'h80, 8'h01);

        // reset mid-burst
        wait_log("rst_b_rd", base2 + 7, 1000);
        repeat (5) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_outs("rst_mid", 16'h0, 16'h0, 16'h0, 16'h0);
        check("rst_mid_busy",  busy, 0);
        check("rst_mid_start", i2c_start, 0);
        check("rst_mid_rw",    i2c_rw, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base3 = log_reg.size();
        wait_log("rst_restart", base3 + 1, 200);
        check_wr("rst_restart_w", base3, 8'h80, 8'h01);
        wait_sig("sv3_seen", 0, 2000);
        check_outs("burst3", 16'h4241, 16'h4443, 16'h4645, 16'h4847);
        repeat (2) @(negedge clk);

        check("start_while_done", start_viol, 0);
        check("out_glitch", glitch, 0);
        check("addr_const", addr_bad, 0);
        check("sv_total", sv_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running, expected finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/tcs3472_ctrl.md
Name: tcs3472_ctrl

Overview:
Measurement sequencer for the TCS3472 colour sensor. It drives the single-byte I2C master's command interface (start/rw/reg_addr/data, done/data_out) and performs these steps in order: power-up, integration-time configuration, ADC enable, integration wait, and an 8-byte read of the C/R/G/B data registers. It assembles the four 16-bit channel values and publishes them atomically, with a one-cycle valid strobe, to the downstream colour-classification logic.

Parameters:
SLAVE_ADDR, 7'h29, sensor 7-bit I2C address
ATIME_VAL, 8'hF6, value written to ATIME (10 integration cycles, ~24 ms)
PON_WAIT, 125000, clk cycles between PON and AEN (2.5 ms @ 50 MHz)
INTEG_WAIT, 1500000, clk cycles between AEN / previous publish and next read burst (30 ms)
TIMEOUT, 200000, max clk cycles from i2c_start to i2c_done before error

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous reset, active-high
enable  in  1  level; 1 = continuous measurement, 0 = power sensor down and idle
i2c_start  out  1  transaction request to I2C master
i2c_rw  out  1  0 = write, 1 = read
i2c_addr  out  7  constant SLAVE_ADDR
i2c_reg_addr  out  8  command byte = 8'h80 | register
i2c_data_wr  out  8  write data
i2c_data_rd  in  8  read data from master
i2c_done  in  1  transaction complete from master (may stay high for many clk cycles)
clear_o, red_o, green_o, blue_o  out  16 each  last published channel values
sample_valid  out  1  one-cycle pulse when channel outputs update
busy  out  1  high in every state except IDLE and ERROR
error  out  1  sticky timeout flag

Behaviour:
- Reset: every output is 0 except i2c_addr = SLAVE_ADDR. The FSM goes to IDLE and the timer is cleared. Reset mid-transaction simply abandons the transaction; the master is reset on the same rst.
- Transaction handshake (TXN sub-sequence, used by every bus step):
  - ISSUE: drive rw, reg_addr and data_wr, then assert i2c_start. Hold all of these stable.
  - WAIT_DONE: the first clk edge with i2c_done = 1 captures i2c_data_rd (reads only). i2c_start is deasserted on the next cycle.
  - RELEASE: wait for i2c_done = 0 before the next ISSUE. There are never back-to-back starts on the same done.
  - Timeout: the timer loads TIMEOUT at ISSUE. If it reaches 0 in WAIT_DONE, set error, drop i2c_start, and go to ERROR.
- States and transitions:
  - IDLE: if enable = 1, go to WR_PON.
  - WR_PON: write reg 0x00 (cmd 0x80), data 0x01. Then WAIT_PON.
  - WAIT_PON: count PON_WAIT cycles. Then WR_ATIME.
  - WR_ATIME: write reg 0x01 (cmd 0x81), data ATIME_VAL. Then WR_AEN.
  - WR_AEN: write reg 0x00, data 0x03. Then WAIT_INT.
  - WAIT_INT: count INTEG_WAIT cycles. Then RD_BURST with idx = 0.
  - RD_BURST: read cmd 0x80 | (0x14 + idx) for idx 0..7. Byte order is CL, CH, RL, RH, GL, GH, BL, BH.
    - Even idx: store to an 8-bit low shadow.
    - Odd idx: write {data, low} into a 16-bit channel shadow.
    - After idx 7, go to PUBLISH.
  - PUBLISH: copy all four shadows to the outputs in the same cycle and pulse sample_valid for one cycle. Then WAIT_INT (if enable = 1) or WR_OFF.
  - WR_OFF: write reg 0x00, data 0x00. Then IDLE.
  - ERROR: busy = 0, error = 1, i2c_start = 0. Leave when enable = 0; error is cleared on that exit and the next state is IDLE. No sensor write is issued.
- Enable deasserted mid-operation:
  - During WAIT_PON or WAIT_INT: abort the wait and go to WR_OFF.
  - During a TXN: complete that transaction (never abort a bus transfer), then go to WR_OFF.
  - During RD_BURST: shadows are discarded and outputs keep their old values (no partial publish).
- Enable reasserted during WR_OFF: finish WR_OFF and IDLE, then restart from WR_PON.
- Outputs hold their last published values indefinitely, including across error. Only rst zeroes them.
- Single shared down-counter, 21 bits, serves the PON, INTEG and TIMEOUT waits. Waits are never concurrent.

Decomposition:
- Package tcs3472_pkg:
  - command bit 8'h80
  - register addresses ENABLE 0x00, ATIME 0x01, CDATAL 0x14
  - ENABLE values PON 0x01, PON|AEN 0x03, OFF 0x00
  - state encoding localparams
- Sub-module tcs_wait_timer: load value, load strobe, decrement every clk, zero flag. It is instantiated once.

Test Plan:
- Bench uses an I2C-master behavioural mock (done after 20 clk, held 5 clk) and PON_WAIT = 10, INTEG_WAIT = 50, TIMEOUT = 100.
- Reset then enable = 1 → the first three transactions are exactly:
  - write 0x80 / 0x01
  - write 0x81 / 0xF6
  - write 0x80 / 0x03
  - i2c_addr = 0x29 throughout.
- Mock returns bytes 0x11..0x18 for regs 0x94..0x9B → clear_o = 0x1211, red_o = 0x1413, green_o = 0x1615, blue_o = 0x1817, sample_valid high exactly 1 cycle, all four updated on the same edge.
- Enable held → a second burst starts 50 cycles after PUBLISH and a second sample_valid occurs. Check i2c_start is never reasserted while i2c_done = 1.
- Enable dropped at the 4th read of a burst → that read completes, then write 0x80 / 0x00, then IDLE; outputs unchanged, no sample_valid.
- Mock never asserts done on WR_ATIME → error = 1 at cycle 100 after start, busy = 0, i2c_start = 0. Dropping enable clears error; re-enabling restarts from write 0x80 / 0x01.
- rst pulsed mid-RD_BURST → all outputs 0 asynchronously and FSM in IDLE; with enable = 1, the sequence restarts at WR_PON.
